// File: rtl/encrypt_sequencer_if.sv
// ---------------------------------------------------------------------------
// encrypt_sequencer_if
//   Groups the host control handshake and the datapath-facing outputs of
//   encrypt_sequencer into one bundle.
//
//   Optional feature macro: ENC_SEQ_DECRYPT_EN (adds the dec signal).
//
//   Signals
//     start  host -> seq   begin one block; only looked at while idle
//     stall  host -> seq   freeze sequencing for this cycle
//     dec    host -> seq   (ENC_SEQ_DECRYPT_EN only) sampled with start
//     s      seq  -> dp    5-bit micro-step code for encrypt_logic
//     we     seq  -> dp    regfile write enable for the step on s
//     sum    seq  -> dp    current TEA round sum
//     round  seq  -> dp    current round index
//     busy   seq  -> host  high while a block is in progress (RUN and FIN)
//     done   seq  -> host  one-cycle completion pulse
//
//   Modports
//     master : host/datapath side (drives start/stall[/dec])
//     slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface encrypt_sequencer_if #(
    parameter int ROUND_W = 6
);
    logic               start;
    logic               stall;
`ifdef ENC_SEQ_DECRYPT_EN
    logic               dec;
`endif
    logic [4:0]         s;
    logic               we;
    logic [31:0]        sum;
    logic [ROUND_W-1:0] round;
    logic               busy;
    logic               done;

`ifdef ENC_SEQ_DECRYPT_EN
    modport master (
        output start, stall, dec,
        input  s, we, sum, round, busy, done
    );
    modport slave (
        input  start, stall, dec,
        output s, we, sum, round, busy, done
    );
`else
    modport master (
        output start, stall,
        input  s, we, sum, round, busy, done
    );
    modport slave (
        input  start, stall,
        output s, we, sum, round, busy, done
    );
`endif
endinterface

// File: rtl/encrypt_sequencer.sv
// ---------------------------------------------------------------------------
// encrypt_sequencer
//   Steps the encrypt_logic decoder through LAST_STEP+1 micro-steps per round
//   for ROUNDS rounds, owns the TEA round-sum register, generates the
//   regfile write strobe and the start/busy/done handshake.
//
//   Optional feature macro: ENC_SEQ_DECRYPT_EN
//     When defined, bus.dec is sampled with start. dec=1 runs the steps
//     LAST_STEP down to 0, starts the sum at DELTA*ROUNDS and subtracts DELTA
//     at each round boundary. dec=0 behaves like the encrypt-only build.
//
//   Ports
//     clk_i        clock, rising edge
//     rst_n_i      asynchronous active-low reset
//     bus          encrypt_sequencer_if.slave (start/stall[/dec] in,
//                  s/we/sum/round/busy/done out)
//     dbg_state_o  current FSM state (IDLE=0, RUN=1, FIN=2)
//
//   Handshake: start is a level sampled only in IDLE; a block is accepted on
//   the edge where start=1 in IDLE and busy rises the next cycle. start seen
//   in RUN or FIN is dropped, never queued. done pulses for exactly one cycle
//   (the FIN cycle); the first IDLE cycle after FIN may accept the next start.
//   stall=1 in RUN suppresses we and freezes s/step/round/sum for that cycle.
// ---------------------------------------------------------------------------
module encrypt_sequencer #(
    parameter int          ROUNDS    = 32,
    parameter int          LAST_STEP = 23,
    parameter logic [31:0] DELTA     = 32'h9E3779B9,
    parameter int          ROUND_W   = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    encrypt_sequencer_if.slave   bus,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam logic [4:0]         LAST_S       = 5'(LAST_STEP);
    localparam logic [ROUND_W-1:0] LAST_ROUND   = ROUND_W'(ROUNDS - 1);
    localparam logic [63:0]        SUM_PROD     = 64'(DELTA) * 64'(ROUNDS);
    localparam logic [31:0]        DEC_SUM_INIT = SUM_PROD[31:0];

    state_e             state_q, state_d;
    logic [4:0]         step_q, step_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [31:0]        sum_q, sum_d;

    logic start_dec;   // direction requested with start
    logic run_dec;     // direction of the block in progress
    logic step_end;    // current step is the final step of the round
    logic last_round;
    logic advance;     // RUN cycle that issues a step

`ifdef ENC_SEQ_DECRYPT_EN
    logic dec_q, dec_d;

    assign start_dec = bus.dec;
    assign run_dec   = dec_q;
`else
    assign start_dec = 1'b0;
    assign run_dec   = 1'b0;
`endif

    // Decrypt walks the steps downwards, so its round ends at step 0.
    assign step_end   = run_dec ? (step_q == 5'd0) : (step_q == LAST_S);
    assign last_round = (round_q == LAST_ROUND);
    assign advance    = (state_q == ST_RUN) && !bus.stall;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (advance && step_end && last_round) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Step / round / sum counters
    // -----------------------------------------------------------------------
    always_comb begin
        step_d  = step_q;
        round_d = round_q;
        sum_d   = sum_q;
`ifdef ENC_SEQ_DECRYPT_EN
        dec_d   = dec_q;
`endif
        if ((state_q == ST_IDLE) && bus.start) begin
            step_d  = start_dec ? LAST_S : 5'd0;
            round_d = '0;
            sum_d   = start_dec ? DEC_SUM_INIT : DELTA;
`ifdef ENC_SEQ_DECRYPT_EN
            dec_d   = start_dec;
`endif
        end else if (advance) begin
            if (step_end) begin
                // The final step of the last round leaves the counters
                // untouched so round/sum keep their last value through FIN
                // and IDLE.
                if (!last_round) begin
                    step_d  = run_dec ? LAST_S : 5'd0;
                    round_d = round_q + ROUND_W'(1);
                    sum_d   = run_dec ? (sum_q - DELTA) : (sum_q + DELTA);
                end
            end else begin
                step_d = run_dec ? (step_q - 5'd1) : (step_q + 5'd1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            step_q  <= '0;
            round_q <= '0;
            sum_q   <= '0;
`ifdef ENC_SEQ_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            step_q  <= step_d;
            round_q <= round_d;
            sum_q   <= sum_d;
`ifdef ENC_SEQ_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        bus.s       = 5'd0;
        bus.we      = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.sum     = sum_q;
        bus.round   = round_q;
        dbg_state_o = state_q;
        unique case (state_q)
            ST_RUN: begin
                bus.s    = step_q;
                bus.we   = !bus.stall;
                bus.busy = 1'b1;
            end
            ST_FIN: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_encrypt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_encrypt_sequencer
//   Directed block runs with a reference model that derives every expected
//   output from the number of steps issued so far (round = n / steps-per-
//   round, step = n % steps-per-round, sum = DELTA * (round+1)).
// ---------------------------------------------------------------------------
module tb_encrypt_sequencer;

  localparam int          ROUNDS    = 32;
  localparam int          LAST_STEP = 23;
  localparam int          ROUND_W   = 6;
  localparam logic [31:0] DELTA     = 32'h9E3779B9;
  localparam int          SPR       = LAST_STEP + 1;
  localparam int          TOTAL     = ROUNDS * SPR;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_FIN  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  encrypt_sequencer_if #(.ROUND_W(ROUND_W)) bus();

  encrypt_sequencer #(
    .ROUNDS(ROUNDS), .LAST_STEP(LAST_STEP), .DELTA(DELTA), .ROUND_W(ROUND_W)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int               m_phase;
  int               m_i;
  logic [31:0]      m_sum;
  logic [ROUND_W-1:0] m_round;
  bit               m_dec;
  int               cyc = 0;
  int               stall_cnt;
  int               done_cyc;
  int               done_hits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_sum(input int r, input bit d);
    if (d) return DELTA * 32'(ROUNDS - r);
    return DELTA * 32'(r + 1);
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_s"},     32'(bus.s),     32'd0);
    check({tag, "_we"},    32'(bus.we),    32'd0);
    check({tag, "_sum"},   bus.sum,        32'd0);
    check({tag, "_round"}, 32'(bus.round), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_done"},  32'(bus.done),  32'd0);
  endtask

  // One clock cycle: drive inputs after the edge, check against the model,
  // then advance the model by what the next edge will sample.
  task automatic step_cycle(input bit stall_v, input bit start_v, input bit dec_v, input string tag);
    logic [31:0] e_s, e_we, e_sum, e_round, e_busy, e_done;
    int r, st;
    @(posedge clk);
    cyc++;
    #1;
    bus.stall = stall_v;
    bus.start = start_v;
`ifdef ENC_SEQ_DECRYPT_EN
    bus.dec = dec_v;
`endif
    #1;
    e_s = 0; e_we = 0; e_sum = m_sum; e_round = 32'(m_round); e_busy = 0; e_done = 0;
    if (m_phase == PH_RUN) begin
      r  = m_i / SPR;
      st = m_i % SPR;
      if (m_dec) st = LAST_STEP - st;
      e_s = 32'(st);
      e_we = {31'd0, !stall_v};
      e_sum = model_sum(r, m_dec);
      e_round = 32'(r);
      e_busy = 1;
      m_sum = e_sum;
      m_round = ROUND_W'(r);
    end else if (m_phase == PH_FIN) begin
      e_busy = 1;
      e_done = 1;
    end
    check({tag, "_s"},     32'(bus.s),     e_s);
    check({tag, "_we"},    32'(bus.we),    e_we);
    check({tag, "_sum"},   bus.sum,        e_sum);
    check({tag, "_round"}, 32'(bus.round), e_round);
    check({tag, "_busy"},  32'(bus.busy),  e_busy);
    check({tag, "_done"},  32'(bus.done),  e_done);
    if (bus.done === 1'b1) begin
      done_cyc = cyc;
      done_hits++;
    end
    // model transition at the coming edge
    case (m_phase)
      PH_IDLE: if (start_v) begin
        m_phase = PH_RUN;
        m_i = 0;
`ifdef ENC_SEQ_DECRYPT_EN
        m_dec = dec_v;
`else
        m_dec = 1'b0;
`endif
      end
      PH_RUN: if (!stall_v) begin
        stall_cnt = stall_cnt;
        m_i++;
        if (m_i == TOTAL) m_phase = PH_FIN;
      end else begin
        stall_cnt++;
      end
      default: m_phase = PH_IDLE;
    endcase
  endtask

  // mode 0: no stalls, 1: five stalls at round 3 step 10,
  // 2: random stalls and start pulses, 4: start pulses then stop at step 100
  task automatic run_block(input int mode, input bit dec_v, input string tag);
    int start_cyc, n, pre_i, pre_phase;
    bit stall_v, start_v;
    stall_cnt = 0;
    done_cyc = -1;
    done_hits = 0;
    step_cycle(1'b0, 1'b1, dec_v, {tag, "_start"});
    start_cyc = cyc;
    n = 0;
    while (m_phase != PH_IDLE && n < 3000) begin
      if (mode == 4 && m_phase == PH_RUN && m_i == 100) break;
      stall_v = 1'b0;
      start_v = 1'b0;
      if (m_phase == PH_RUN) begin
        case (mode)
          1: stall_v = (m_i == 3 * SPR + 10) && (stall_cnt < 5);
          2: begin
            stall_v = ($urandom_range(0, 3) == 0);
            start_v = 1'($urandom_range(0, 1));
          end
          4: start_v = 1'($urandom_range(0, 1));
          default: ;
        endcase
      end else if (mode == 2) begin
        start_v = 1'($urandom_range(0, 1));
      end
      pre_i = m_i;
      pre_phase = m_phase;
      step_cycle(stall_v, start_v, dec_v, tag);
      if (pre_phase == PH_RUN && pre_i == 0) begin
        check({tag, "_first_sum"}, bus.sum, dec_v ? 32'hC6EF3720 : 32'h9E3779B9);
        check({tag, "_first_s"}, 32'(bus.s), dec_v ? 32'd23 : 32'd0);
      end
      if (pre_phase == PH_RUN && pre_i == (ROUNDS - 1) * SPR)
        check({tag, "_last_sum"}, bus.sum, dec_v ? 32'h9E3779B9 : 32'hC6EF3720);
      n++;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    if (mode != 4) begin
      check({tag, "_no_timeout"}, 32'(n < 3000), 32'd1);
      check({tag, "_done_once"}, 32'(done_hits), 32'd1);
      check({tag, "_latency"}, 32'(done_cyc - start_cyc), 32'(TOTAL + 1 + stall_cnt));
      if (mode == 0) check({tag, "_latency769"}, 32'(done_cyc - start_cyc), 32'd769);
      if (mode == 1) check({tag, "_latency774"}, 32'(done_cyc - start_cyc), 32'd774);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stall = 1'b0;
`ifdef ENC_SEQ_DECRYPT_EN
    bus.dec = 1'b0;
`endif
    m_phase = PH_IDLE; m_i = 0; m_sum = '0; m_round = '0; m_dec = 1'b0;
    done_cyc = -1; done_hits = 0; stall_cnt = 0;

    // reset held: start and stall pulses must have no effect
    rst_n = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1;
      bus.start = (n == 1);
      bus.stall = (n == 2);
      #1;
      check_zero("rst_hold");
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.stall = 1'b0;
    rst_n = 1'b1;

    repeat (2) step_cycle(1'b0, 1'b0, 1'b0, "idle");

    run_block(0, 1'b0, "plain");
    run_block(1, 1'b0, "stall5");
    run_block(2, 1'b0, "rand_a");
    run_block(2, 1'b0, "rand_b");
`ifdef ENC_SEQ_DECRYPT_EN
    run_block(0, 1'b1, "dec");
    run_block(2, 1'b1, "dec_rand");
    run_block(0, 1'b0, "after_dec");
`endif

    // reset in the middle of a block at step 100
    run_block(4, 1'b0, "rst_mid");
    check("rst_mid_reached100", 32'(m_i), 32'd100);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid_async");
    m_phase = PH_IDLE; m_i = 0; m_sum = '0; m_round = '0;
    @(negedge clk);
    rst_n = 1'b1;
    done_hits = 0;
    repeat (40) step_cycle(1'b0, 1'b0, 1'b0, "post_rst");
    check("post_rst_no_done", 32'(done_hits), 32'd0);

    // a fresh block still works after the abandoned one
    run_block(0, 1'b0, "post_rst_block");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
